// File: rtl/addr_gen_pkg.sv
// Shared types and the lane address helper for the sequential address generator.
package addr_gen_pkg;

  // Widest address the lane helper handles; per-instance widths are narrower.
  localparam int MAX_AW = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    MODE_STRIDE = 1'b0,
    MODE_INC    = 1'b1
  } mode_e;

  // ((base + k*stride) mod 2^aw) ^ mask.
  // The xor is bitwise, so truncating once at the end gives the same modular result.
  function automatic logic [MAX_AW-1:0] lane_addr(
    input logic [MAX_AW-1:0] base,
    input logic [MAX_AW-1:0] stride,
    input logic [MAX_AW-1:0] mask,
    input int                k,
    input int                aw
  );
    logic [MAX_AW-1:0] kk;
    logic [MAX_AW-1:0] sum;
    logic [MAX_AW-1:0] keep;
    kk   = MAX_AW'(k);
    sum  = base + kk * stride;
    keep = (aw >= MAX_AW) ? '1 : ((MAX_AW'(1) << aw) - MAX_AW'(1));
    return (sum ^ mask) & keep;
  endfunction

endpackage

// File: rtl/addr_lane.sv
// One lane of the address generator: ((base + K*stride) ^ mask), purely combinational.
module addr_lane
  import addr_gen_pkg::*;
#(
  parameter int AW = 10,
  parameter int K  = 0
) (
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] stride,
  input  logic [AW-1:0] mask,
  output logic [AW-1:0] addr
);

  // Zero-extend into the helper's width and truncate the result back to AW bits.
  always_comb begin
    addr = AW'(lane_addr(MAX_AW'(base), MAX_AW'(stride), MAX_AW'(mask), K, AW));
  end

endmodule

// File: rtl/addr_gen_seq.sv
// Sequential address generator: latches a job on go, streams cfg_count beats of
// NCH lane addresses over a valid/ready handshake, then pulses done.
module addr_gen_seq
  import addr_gen_pkg::*;
#(
  parameter int AW  = 10,
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [AW-1:0]     cfg_start,
  input  logic [AW-1:0]     cfg_stride,
  input  logic [AW-1:0]     cfg_mask,
  input  logic              cfg_mode,
  input  logic [CW-1:0]     cfg_count,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [NCH*AW-1:0] out_addr,
  output logic              busy,
  output logic              done
);

  localparam logic [AW-1:0] NCH_AW = AW'(NCH);

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d;
  logic [AW-1:0]   base_q, base_d;
  logic [AW-1:0]   stride_q, stride_d;
  logic [AW-1:0]   mask_q, mask_d;
  logic [CW-1:0]   remain_q, remain_d;
  logic            valid_d;
  logic            done_d;
  logic [NCH*AW-1:0] addr_d;

  logic [AW-1:0]     calc_base, calc_stride, calc_mask;
  logic [AW-1:0]     step;
  logic [NCH*AW-1:0] lanes;
  logic              load_addr;
  logic              clear_addr;

  // Lane adders see the base/stride/mask of the beat about to be registered.
  for (genvar k = 0; k < NCH; k++) begin : g_lane
    addr_lane #(
      .AW (AW),
      .K  (k)
    ) u_lane (
      .base   (calc_base),
      .stride (calc_stride),
      .mask   (calc_mask),
      .addr   (lanes[k*AW +: AW])
    );
  end

  assign step = (mode_q == MODE_INC) ? AW'(1) : AW'(NCH_AW * stride_q);
  assign busy = (state_q == RUN);

  // Next-state, next-job-config and next-output decode.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    base_d      = base_q;
    stride_d    = stride_q;
    mask_d      = mask_q;
    remain_d    = remain_q;
    valid_d     = out_valid;
    done_d      = 1'b0;
    calc_base   = base_q;
    calc_stride = stride_q;
    calc_mask   = mask_q;
    load_addr   = 1'b0;
    clear_addr  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (go) begin
          if (cfg_count != '0) begin
            mode_d      = mode_e'(cfg_mode);
            base_d      = cfg_start;
            stride_d    = cfg_stride;
            mask_d      = cfg_mask;
            remain_d    = cfg_count;
            state_d     = RUN;
            valid_d     = 1'b1;
            calc_base   = cfg_start;
            calc_stride = cfg_stride;
            calc_mask   = cfg_mask;
            load_addr   = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (out_valid && out_ready) begin
          if (remain_q > CW'(1)) begin
            remain_d  = remain_q - CW'(1);
            base_d    = base_q + step;
            calc_base = base_q + step;
            load_addr = 1'b1;
          end else begin
            remain_d   = '0;
            valid_d    = 1'b0;
            done_d     = 1'b1;
            state_d    = IDLE;
            clear_addr = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear_addr)     addr_d = '0;
    else if (load_addr) addr_d = lanes;
    else                addr_d = out_addr;
  end

  // State, job config and registered outputs; reset drops any in-flight beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= MODE_STRIDE;
      base_q    <= '0;
      stride_q  <= '0;
      mask_q    <= '0;
      remain_q  <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      base_q    <= base_d;
      stride_q  <= stride_d;
      mask_q    <= mask_d;
      remain_q  <= remain_d;
      out_valid <= valid_d;
      out_addr  <= addr_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_addr_gen_seq.sv
// Directed bench for addr_gen_seq with hand-computed lane addresses.
module tb_addr_gen_seq;

  localparam int AW  = 10;
  localparam int NCH = 4;
  localparam int CW  = 16;

  logic              clk;
  logic              rst_n;
  logic              go;
  logic [AW-1:0]     cfg_start;
  logic [AW-1:0]     cfg_stride;
  logic [AW-1:0]     cfg_mask;
  logic              cfg_mode;
  logic [CW-1:0]     cfg_count;
  logic              out_ready;
  logic              out_valid;
  logic [NCH*AW-1:0] out_addr;
  logic              busy;
  logic              done;

  int vectors = 0;
  int errors  = 0;
  int accepted = 0;
  int acc0;

  addr_gen_seq #(
    .AW  (AW),
    .NCH (NCH),
    .CW  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .cfg_start  (cfg_start),
    .cfg_stride (cfg_stride),
    .cfg_mask   (cfg_mask),
    .cfg_mode   (cfg_mode),
    .cfg_count  (cfg_count),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_addr   (out_addr),
    .busy       (busy),
    .done       (done)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts handshakes seen by the consumer.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) accepted <= accepted + 1;
  end

  // Hard stop if the sequence somehow stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic g, input logic [AW-1:0] start,
                               input logic [AW-1:0] stride, input logic [AW-1:0] mask,
                               input logic mode, input logic [CW-1:0] count);
    go         = g;
    cfg_start  = start;
    cfg_stride = stride;
    cfg_mask   = mask;
    cfg_mode   = mode;
    cfg_count  = count;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [NCH*AW-1:0] beat(input logic [AW-1:0] l0, input logic [AW-1:0] l1,
                                             input logic [AW-1:0] l2, input logic [AW-1:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
    tick();
    tick();
    checkOutput("reset_valid", 64'(out_valid), 64'(0));
    checkOutput("reset_addr",  64'(out_addr),  64'(0));
    checkOutput("reset_busy",  64'(busy),      64'(0));
    checkOutput("reset_done",  64'(done),      64'(0));
    rst_n = 1'b1;
    tick();

    $display("[TB] basic stride job");
    out_ready = 1'b1;
    applyStimulus(1'b1, 10'h005, 10'h003, 10'h0F0, 1'b0, 16'd2);
    tick();
    applyStimulus(1'b0, 10'h3AA, 10'h155, 10'h2AA, 1'b1, 16'd9);
    checkOutput("basic_b1_valid", 64'(out_valid), 64'(1));
    checkOutput("basic_b1_busy",  64'(busy),      64'(1));
    checkOutput("basic_b1_addr",  64'(out_addr),  64'(beat(10'h0F5, 10'h0F8, 10'h0FB, 10'h0FE)));
    tick();
    checkOutput("basic_b2_valid", 64'(out_valid), 64'(1));
    checkOutput("basic_b2_addr",  64'(out_addr),  64'(beat(10'h0E1, 10'h0E4, 10'h0E7, 10'h0EA)));
    checkOutput("basic_b2_done",  64'(done),      64'(0));
    tick();
    checkOutput("basic_end_done",  64'(done),      64'(1));
    checkOutput("basic_end_valid", 64'(out_valid), 64'(0));
    checkOutput("basic_end_busy",  64'(busy),      64'(0));
    checkOutput("basic_end_addr",  64'(out_addr),  64'(0));
    tick();
    checkOutput("basic_done_pulse", 64'(done), 64'(0));

    $display("[TB] wrap-around job");
    applyStimulus(1'b1, 10'h3FE, 10'h001, 10'h000, 1'b0, 16'd1);
    tick();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
    checkOutput("wrap_addr", 64'(out_addr), 64'(beat(10'h3FE, 10'h3FF, 10'h000, 10'h001)));
    tick();
    checkOutput("wrap_done",  64'(done),      64'(1));
    checkOutput("wrap_valid", 64'(out_valid), 64'(0));
    tick();

    $display("[TB] INC mode job");
    applyStimulus(1'b1, 10'h010, 10'h004, 10'h000, 1'b1, 16'd3);
    tick();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
    checkOutput("inc_b1", 64'(out_addr), 64'(beat(10'h010, 10'h014, 10'h018, 10'h01C)));
    tick();
    checkOutput("inc_b2", 64'(out_addr), 64'(beat(10'h011, 10'h015, 10'h019, 10'h01D)));
    tick();
    checkOutput("inc_b3", 64'(out_addr), 64'(beat(10'h012, 10'h016, 10'h01A, 10'h01E)));
    tick();
    checkOutput("inc_done", 64'(done), 64'(1));
    tick();

    $display("[TB] backpressure job");
    acc0 = accepted;
    out_ready = 1'b0;
    applyStimulus(1'b1, 10'h005, 10'h003, 10'h0F0, 1'b0, 16'd2);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus((i == 1), 10'h200, 10'h011, 10'h000, 1'b1, 16'd7);
      checkOutput($sformatf("bp_hold_valid%0d", i), 64'(out_valid), 64'(1));
      checkOutput($sformatf("bp_hold_addr%0d", i), 64'(out_addr),
                  64'(beat(10'h0F5, 10'h0F8, 10'h0FB, 10'h0FE)));
      tick();
    end
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
    checkOutput("bp_hold_addr_end", 64'(out_addr), 64'(beat(10'h0F5, 10'h0F8, 10'h0FB, 10'h0FE)));
    out_ready = 1'b1;
    tick();
    checkOutput("bp_b2_addr", 64'(out_addr), 64'(beat(10'h0E1, 10'h0E4, 10'h0E7, 10'h0EA)));
    tick();
    checkOutput("bp_done",  64'(done), 64'(1));
    tick();
    checkOutput("bp_beats", 64'(accepted - acc0), 64'(2));
    checkOutput("bp_idle_valid", 64'(out_valid), 64'(0));

    $display("[TB] zero-count job then back-to-back go");
    applyStimulus(1'b1, 10'h055, 10'h001, 10'h000, 1'b0, 16'd0);
    tick();
    checkOutput("zero_done",  64'(done),      64'(1));
    checkOutput("zero_valid", 64'(out_valid), 64'(0));
    checkOutput("zero_busy",  64'(busy),      64'(0));
    applyStimulus(1'b1, 10'h100, 10'h001, 10'h000, 1'b0, 16'd1);
    tick();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
    checkOutput("b2b_done",  64'(done),      64'(0));
    checkOutput("b2b_valid", 64'(out_valid), 64'(1));
    checkOutput("b2b_addr",  64'(out_addr),  64'(beat(10'h100, 10'h101, 10'h102, 10'h103)));
    tick();
    checkOutput("b2b_end_done", 64'(done), 64'(1));
    tick();

    $display("[TB] reset mid-run");
    applyStimulus(1'b1, 10'h005, 10'h003, 10'h0F0, 1'b0, 16'd5);
    tick();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
    checkOutput("rst_b1_addr", 64'(out_addr), 64'(beat(10'h0F5, 10'h0F8, 10'h0FB, 10'h0FE)));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("rst_mid_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_mid_busy",  64'(busy),      64'(0));
    checkOutput("rst_mid_done",  64'(done),      64'(0));
    checkOutput("rst_mid_addr",  64'(out_addr),  64'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("rst_quiet_valid%0d", i), 64'(out_valid), 64'(0));
      checkOutput($sformatf("rst_quiet_done%0d", i),  64'(done),      64'(0));
    end
    applyStimulus(1'b1, 10'h3FE, 10'h001, 10'h000, 1'b0, 16'd1);
    tick();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
    checkOutput("rst_restart_addr", 64'(out_addr), 64'(beat(10'h3FE, 10'h3FF, 10'h000, 10'h001)));
    tick();
    checkOutput("rst_restart_done", 64'(done), 64'(1));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
